// File: rtl/parity_frame_ctrl_if.sv
// Host/serial-line bundle for parity_frame_ctrl.
// PARITY_ERR_CNT_EN adds err_clr / err_cnt.
interface parity_frame_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             valid;
  logic             x;
  logic             busy;
  logic             run_par;
  logic [7:0]       bit_cnt;
  logic             done;
  logic             parity_err;
  logic [CNT_W-1:0] frame_cnt;
`ifdef PARITY_ERR_CNT_EN
  logic             err_clr;
  logic [7:0]       err_cnt;

  modport master (
    output start, abort, valid, x, err_clr,
    input  busy, run_par, bit_cnt, done,
    input  parity_err, frame_cnt, err_cnt
  );
  modport slave (
    input  start, abort, valid, x, err_clr,
    output busy, run_par, bit_cnt, done,
    output parity_err, frame_cnt, err_cnt
  );
`else
  modport master (
    output start, abort, valid, x,
    input  busy, run_par, bit_cnt, done,
    input  parity_err, frame_cnt
  );
  modport slave (
    input  start, abort, valid, x,
    output busy, run_par, bit_cnt, done,
    output parity_err, frame_cnt
  );
`endif
endinterface

// File: rtl/parity_frame_ctrl.sv
// Serial running-parity framer: FRAME_LEN data bits + 1 parity bit.
// Optional saturating error counter under PARITY_ERR_CNT_EN.
module parity_frame_ctrl #(
  parameter int FRAME_LEN  = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  parity_frame_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    DONE
  } state_e;

  localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

  state_e           state_q;
  logic             busy_q;
  logic             run_par_q;
  logic [7:0]       bit_cnt_q;
  logic             done_q;
  logic             perr_q;
  logic [CNT_W-1:0] frame_cnt_q;

  logic err_d;
  logic last_d;
  logic par_hit;

  assign err_d   = bus.x ^ run_par_q ^ PARITY_ODD;
  assign last_d  = (bit_cnt_q == LAST);
  assign par_hit = (state_q == PAR) && bus.valid
                   && !bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      run_par_q   <= 1'b0;
      bit_cnt_q   <= 8'd0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q   <= DATA;
            busy_q    <= 1'b1;
            run_par_q <= 1'b0;
            bit_cnt_q <= 8'd0;
          end
        end
        DATA: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.valid) begin
            run_par_q <= run_par_q ^ bus.x;
            bit_cnt_q <= bit_cnt_q + 8'd1;
            if (last_d) state_q <= PAR;
          end
        end
        PAR: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.valid) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            perr_q      <= err_d;
            frame_cnt_q <= frame_cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.run_par    = run_par_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.done       = done_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_cnt  = frame_cnt_q;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Clear beats a coincident increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_q <= 8'd0;
    end else if (bus.err_clr) begin
      err_cnt_q <= 8'd0;
    end else if (par_hit && err_d
                 && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Directed bench for parity_frame_ctrl.
// Unit 0: even, unit 1: odd, unit 2: CNT_W=2.
module tb_parity_frame_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl_if #(.CNT_W(8)) a_if ();
  parity_frame_ctrl_if #(.CNT_W(8)) b_if ();
  parity_frame_ctrl_if #(.CNT_W(2)) c_if ();

  parity_frame_ctrl #(
    .FRAME_LEN(8), .PARITY_ODD(1'b0), .CNT_W(8)
  ) u_a (.clk(clk), .rst(rst), .bus(a_if));

  parity_frame_ctrl #(
    .FRAME_LEN(8), .PARITY_ODD(1'b1), .CNT_W(8)
  ) u_b (.clk(clk), .rst(rst), .bus(b_if));

  parity_frame_ctrl #(
    .FRAME_LEN(8), .PARITY_ODD(1'b0), .CNT_W(2)
  ) u_c (.clk(clk), .rst(rst), .bus(c_if));

  logic       bsy [3];
  logic       rp  [3];
  logic [7:0] bc  [3];
  logic       dn  [3];
  logic       pe  [3];
  logic [7:0] fc  [3];

  assign bsy[0] = a_if.busy;
  assign bsy[1] = b_if.busy;
  assign bsy[2] = c_if.busy;
  assign rp[0]  = a_if.run_par;
  assign rp[1]  = b_if.run_par;
  assign rp[2]  = c_if.run_par;
  assign bc[0]  = a_if.bit_cnt;
  assign bc[1]  = b_if.bit_cnt;
  assign bc[2]  = c_if.bit_cnt;
  assign dn[0]  = a_if.done;
  assign dn[1]  = b_if.done;
  assign dn[2]  = c_if.done;
  assign pe[0]  = a_if.parity_err;
  assign pe[1]  = b_if.parity_err;
  assign pe[2]  = c_if.parity_err;
  assign fc[0]  = a_if.frame_cnt;
  assign fc[1]  = b_if.frame_cnt;
  assign fc[2]  = {6'b0, c_if.frame_cnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic s,
                       input logic a, input logic v,
                       input logic b);
    case (u)
      0: begin
        a_if.start = s; a_if.abort = a;
        a_if.valid = v; a_if.x = b;
      end
      1: begin
        b_if.start = s; b_if.abort = a;
        b_if.valid = v; b_if.x = b;
      end
      default: begin
        c_if.start = s; c_if.abort = a;
        c_if.valid = v; c_if.x = b;
      end
    endcase
  endtask

  task automatic set_clr(input logic c);
`ifdef PARITY_ERR_CNT_EN
    a_if.err_clr = c;
    b_if.err_clr = 1'b0;
    c_if.err_clr = 1'b0;
`else
    if (c) $display("[TB] err_clr unavailable");
`endif
  endtask

  // Start, 8 bits first-to-last = d[7]..d[0], parity p.
  // Returns in the DONE cycle with inputs idle.
  task automatic run_frame(input int u, input logic [7:0] d,
                           input logic p, input logic clr);
    drive(u, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 7; i >= 0; i--) begin
      drive(u, 1'b0, 1'b0, 1'b1, d[i]);
      tick();
    end
    drive(u, 1'b0, 1'b0, 1'b1, p);
    set_clr(clr);
    tick();
    drive(u, 1'b0, 1'b0, 1'b0, 1'b0);
    set_clr(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    tests++;
    if ({bsy[0], rp[0], dn[0], pe[0]} !== 4'b0000
        || bc[0] !== 8'd0 || fc[0] !== 8'd0) begin
      fails++;
      $display("FAIL reset: busy=%b rp=%b dn=%b pe=%b bc=%0d fc=%0d want all 0",
               bsy[0], rp[0], dn[0], pe[0], bc[0], fc[0]);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_even_good();
    run_frame(0, 8'b10110010, 1'b0, 1'b0);
    tests++;
    if (dn[0] !== 1'b1 || pe[0] !== 1'b0 || rp[0] !== 1'b0
        || bc[0] !== 8'd8 || fc[0] !== 8'd1 || bsy[0] !== 1'b1) begin
      fails++;
      $display("FAIL even_good: dn=%b pe=%b rp=%b bc=%0d fc=%0d busy=%b want 1 0 0 8 1 1",
               dn[0], pe[0], rp[0], bc[0], fc[0], bsy[0]);
    end
    tick();
    tests++;
    if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      fails++;
      $display("FAIL done_width: dn=%b busy=%b want 0 0",
               dn[0], bsy[0]);
    end
  endtask

  task automatic test_even_bad();
    run_frame(0, 8'b10110010, 1'b1, 1'b0);
    tests++;
    if (dn[0] !== 1'b1 || pe[0] !== 1'b1 || fc[0] !== 8'd2) begin
      fails++;
      $display("FAIL even_bad: dn=%b pe=%b fc=%0d want 1 1 2",
               dn[0], pe[0], fc[0]);
    end
    tick();
    tick();
    tests++;
    if (pe[0] !== 1'b1) begin
      fails++;
      $display("FAIL err_hold: pe=%b want 1", pe[0]);
    end
    run_frame(0, 8'b10110010, 1'b0, 1'b0);
    tests++;
    if (pe[0] !== 1'b0 || fc[0] !== 8'd3) begin
      fails++;
      $display("FAIL even_recover: pe=%b fc=%0d want 0 3",
               pe[0], fc[0]);
    end
    tick();
  endtask

  task automatic test_odd();
    run_frame(1, 8'b11100000, 1'b0, 1'b0);
    tests++;
    if (dn[1] !== 1'b1 || pe[1] !== 1'b0 || rp[1] !== 1'b1
        || fc[1] !== 8'd1) begin
      fails++;
      $display("FAIL odd_good: dn=%b pe=%b rp=%b fc=%0d want 1 0 1 1",
               dn[1], pe[1], rp[1], fc[1]);
    end
    tick();
    run_frame(1, 8'b11100000, 1'b1, 1'b0);
    tests++;
    if (pe[1] !== 1'b1 || fc[1] !== 8'd2) begin
      fails++;
      $display("FAIL odd_bad: pe=%b fc=%0d want 1 2",
               pe[1], fc[1]);
    end
    tick();
  endtask

  task automatic test_gap();
    logic [7:0] d;
    d = 8'b10110010;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 7; i >= 0; i--) begin
      drive(0, 1'b0, 1'b0, 1'b1, d[i]);
      tick();
      if (i == 4) begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 1'b0, 1'b0, 1'b0, 1'b1);
          tick();
          tests++;
          if (bc[0] !== 8'd4 || rp[0] !== 1'b1) begin
            fails++;
            $display("FAIL gap_hold: bc=%0d rp=%b want 4 1",
                     bc[0], rp[0]);
          end
        end
      end
    end
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (dn[0] !== 1'b1 || pe[0] !== 1'b0 || rp[0] !== 1'b0
        || bc[0] !== 8'd8 || fc[0] !== 8'd4) begin
      fails++;
      $display("FAIL gap_result: dn=%b pe=%b rp=%b bc=%0d fc=%0d want 1 0 0 8 4",
               dn[0], pe[0], rp[0], bc[0], fc[0]);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [4:0] d;
    logic       seen;
    d = 5'b10110;
    seen = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 4; i >= 0; i--) begin
      drive(0, 1'b0, 1'b0, 1'b1, d[i]);
      tick();
    end
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bsy[0] !== 1'b0 || bc[0] !== 8'd5 || rp[0] !== 1'b1) begin
      fails++;
      $display("FAIL abort: busy=%b bc=%0d rp=%b want 0 5 1",
               bsy[0], bc[0], rp[0]);
    end
    for (int k = 0; k < 4; k++) begin
      if (dn[0]) seen = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (seen !== 1'b0 || fc[0] !== 8'd4 || pe[0] !== 1'b0
        || bsy[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_after: done_seen=%b fc=%0d pe=%b busy=%b want 0 4 0 0",
               seen, fc[0], pe[0], bsy[0]);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
    end
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bc[0] !== 8'd3 || bsy[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: bc=%0d busy=%b want 3 1",
               bc[0], bsy[0]);
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if ({bsy[0], rp[0], dn[0], pe[0]} !== 4'b0000
        || bc[0] !== 8'd0 || fc[0] !== 8'd0) begin
      fails++;
      $display("FAIL async_reset: busy=%b rp=%b dn=%b pe=%b bc=%0d fc=%0d want all 0",
               bsy[0], rp[0], dn[0], pe[0], bc[0], fc[0]);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_start_busy();
    logic [7:0] d;
    d = 8'b10110010;
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 7; i >= 0; i--) begin
      drive(0, (i == 5 || i == 2), 1'b0, 1'b1, d[i]);
      tick();
    end
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    tests++;
    if (dn[0] !== 1'b1 || bc[0] !== 8'd8 || pe[0] !== 1'b0
        || fc[0] !== 8'd1) begin
      fails++;
      $display("FAIL start_busy: dn=%b bc=%0d pe=%b fc=%0d want 1 8 0 1",
               dn[0], bc[0], pe[0], fc[0]);
    end
    drive(0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      fails++;
      $display("FAIL start_in_done: busy=%b dn=%b want 0 0",
               bsy[0], dn[0]);
    end
    tick();
  endtask

  task automatic test_abort_start_idle();
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests++;
    if (bsy[0] !== 1'b0 || bc[0] !== 8'd8) begin
      fails++;
      $display("FAIL abort_start_idle: busy=%b bc=%0d want 0 8",
               bsy[0], bc[0]);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] want [5];
    want[0] = 8'd1;
    want[1] = 8'd2;
    want[2] = 8'd3;
    want[3] = 8'd0;
    want[4] = 8'd1;
    for (int f = 0; f < 5; f++) begin
      run_frame(2, 8'b10110010, 1'b0, 1'b0);
      tests++;
      if (dn[2] !== 1'b1 || fc[2] !== want[f]) begin
        fails++;
        $display("FAIL wrap[%0d]: dn=%b fc=%0d want 1 %0d",
                 f, dn[2], fc[2], want[f]);
      end
      tick();
    end
  endtask

`ifdef PARITY_ERR_CNT_EN
  task automatic test_err_cnt();
    for (int f = 0; f < 3; f++) begin
      run_frame(0, 8'b10110010, 1'b1, 1'b0);
      tick();
    end
    tests++;
    if (a_if.err_cnt !== 8'd3) begin
      fails++;
      $display("FAIL err_cnt: got %0d want 3", a_if.err_cnt);
    end
    run_frame(0, 8'b10110010, 1'b1, 1'b1);
    tests++;
    if (a_if.err_cnt !== 8'd0 || pe[0] !== 1'b1) begin
      fails++;
      $display("FAIL err_clr: cnt=%0d pe=%b want 0 1",
               a_if.err_cnt, pe[0]);
    end
    tick();
  endtask
`endif

  initial begin
    rst = 1'b0;
    for (int u = 0; u < 3; u++)
      drive(u, 1'b0, 1'b0, 1'b0, 1'b0);
    set_clr(1'b0);
    test_reset();
    test_even_good();
    test_even_bad();
    test_odd();
    test_gap();
    test_abort();
    test_reset_mid();
    test_start_busy();
    test_abort_start_idle();
    test_wrap();
`ifdef PARITY_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_frame_ctrl.md
Name: parity_frame_ctrl

Overview:
- Sequencer for a serial running-parity datapath.
- Frames a serial bit stream into fixed-length words of FRAME_LEN data bits followed by one parity bit.
- Accumulates running parity over the data bits, checks the received parity bit, and reports per-frame status to a host.
- Sits between the serial line front-end and the status/interrupt logic.

Parameters:
- FRAME_LEN, 8, data bits per frame; legal range 2..255.
- PARITY_ODD, 0, 0 = even parity scheme, 1 = odd parity scheme.
- CNT_W, 8, width of the frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  cancel the current frame; returns to IDLE without a done pulse.
- valid  in  1  qualifies x for one bit this cycle.
- x  in  1  serial bit.
- busy  out  1  high in DATA, PAR, DONE.
- run_par  out  1  running XOR of data bits accepted so far in this frame.
- bit_cnt  out  8  data bits accepted in this frame.
- done  out  1  one-cycle pulse at frame completion.
- parity_err  out  1  result of the last completed frame; held until the next done.
- frame_cnt  out  CNT_W  completed frames; wraps modulo 2^CNT_W.

Behaviour:
- All outputs are registered.
- Reset (rst=0, async): state=IDLE, busy=0, run_par=0, bit_cnt=0, done=0, parity_err=0, frame_cnt=0. Reset asserted mid-frame discards the frame immediately.
- States: IDLE, DATA, PAR, DONE.
- IDLE:
  - start=1 and abort=0 → DATA next cycle; run_par and bit_cnt clear to 0.
  - valid/x are ignored in IDLE, including in the start cycle. The first data bit is accepted the cycle after start.
- DATA:
  - Each cycle with valid=1: run_par <= run_par ^ x, bit_cnt <= bit_cnt+1.
  - When valid=1 and bit_cnt==FRAME_LEN-1 → PAR.
  - valid=0 holds all state; there is no timeout.
- PAR:
  - First cycle with valid=1: expected = run_par ^ PARITY_ODD; err = (x != expected); → DONE.
  - run_par and bit_cnt hold their final values.
- DONE (exactly 1 cycle):
  - done=1; parity_err updates to err in the same cycle done rises; frame_cnt increments (wrap 2^CNT_W-1 → 0).
  - → IDLE. start in the DONE cycle is ignored.
- abort=1 in DATA or PAR:
  - → IDLE next cycle; no done pulse; parity_err and frame_cnt unchanged; run_par and bit_cnt keep their values until the next start.
- abort has priority over valid and start in the same cycle. abort in IDLE or DONE has no effect: DONE still completes.
- start while busy: ignored, not queued.
- Latency: done rises 1 cycle after the PAR-bit valid cycle. The minimum frame is 1 (start) + FRAME_LEN + 1 (parity) + 1 (done) = FRAME_LEN+3 cycles from start to done.

Optional Feature:
- Macro PARITY_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt (8 bits) and input err_clr (1 bit).
  - err_cnt increments on each done with err=1 and saturates at 255.
  - err_clr=1 zeroes err_cnt next cycle; clear wins over a simultaneous increment.
  - Reset value is 0.
- Undefined: neither port exists; no other behaviour changes.

Test Plan:
1. FRAME_LEN=8, PARITY_ODD=0. start, then data 1,0,1,1,0,0,1,0 (four ones) on consecutive valid cycles, parity bit 0 → run_par=0, bit_cnt=8, done pulse 1 cycle, parity_err=0, frame_cnt=1.
2. Same data, parity bit 1 → parity_err=1 on done; next frame with correct parity → parity_err=0, frame_cnt=2.
3. PARITY_ODD=1, data 1,1,1,0,0,0,0,0 (three ones), parity bit 0 → parity_err=0; parity bit 1 → parity_err=1.
4. Gapped valid: valid=0 for 3 cycles between bits 4 and 5 → bit_cnt holds at 4 during the gap, result identical to scenario 1. abort asserted after 5 bits → busy=0 next cycle, no done, frame_cnt unchanged.
5. Reset asserted mid-DATA after 3 bits → all outputs 0 immediately, async (without waiting for a clock edge). start asserted while busy → ignored. abort+start in IDLE → stays IDLE.
6. CNT_W=2: run 5 good frames → frame_cnt sequence 1,2,3,0,1. With PARITY_ERR_CNT_EN: 3 bad frames → err_cnt=3; err_clr coincident with a bad done → err_cnt=0.
